// File: rtl/ram16k_fifo_ctrl_if.sv
// Streaming push/pop handshake bundle between the fabric and ram16k_fifo_ctrl.
// The master side is the producer/consumer; the slave side is the controller.
interface ram16k_fifo_ctrl_if;
   logic        push_valid;
   logic        push_ready;
   logic [31:0] push_data;
   logic        pop_valid;
   logic        pop_ready;
   logic [31:0] pop_data;

   modport master (
      output push_valid, push_data, pop_ready,
      input  push_ready, pop_valid, pop_data
   );

   modport slave (
      input  push_valid, push_data, pop_ready,
      output push_ready, pop_valid, pop_data
   );
endinterface

// File: rtl/ram16k_fifo_ctrl.sv
// First-word-fall-through FIFO controller around one 512x32 registered-read DP RAM.
// A 2-entry output queue hides the RAM read latency so pops sustain one word per clock.
module ram16k_fifo_ctrl #(
   parameter int DEPTH    = 512,
   parameter int AW       = 9,
   parameter int AF_LEVEL = 480,
   parameter int AE_LEVEL = 32
) (
   input  logic                 clk,
   input  logic                 R,
   input  logic                 flush,
   ram16k_fifo_ctrl_if.slave    strm,
   output logic [9:0]           count,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 ram_wen,
   output logic                 ram_ren,
   output logic [AW-1:0]        ram_waddr,
   output logic [AW-1:0]        ram_raddr,
   output logic [31:0]          ram_d_in,
   output logic [31:0]          ram_wenb,
   input  logic [31:0]          ram_d_out
);

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t        state_r, state_nxt_s;
   logic [AW-1:0] wptr_r, rptr_r, wptr_nxt_s, rptr_nxt_s;
   logic [9:0]    ram_cnt_r, ram_cnt_nxt_s, count_r, count_nxt_s;
   logic          inflight_r;
   logic [1:0]    oq_occ_r, oq_occ_nxt_s, occ_after_pop_s;
   logic [31:0]   oq0_r, oq1_r, oq0_nxt_s, oq1_nxt_s;
   logic          push_ready_r, almost_full_r, almost_empty_r;
   logic          flush_s, push_fire_s, pop_fire_s, issue_s, ret_s;
   logic [2:0]    pending_s;

   // Flush sequencing: a single FLUSH cycle after every flush request seen in RUN.
   always_comb begin
      state_nxt_s = ST_RUN;
      case (state_r)
         ST_RUN: begin
            if (flush) begin
               state_nxt_s = ST_FLUSH;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_FLUSH: state_nxt_s = ST_RUN;
         default:  state_nxt_s = ST_RUN;
      endcase
   end

   // Handshakes, read issue and next values of pointers, counters and output queue.
   always_comb begin
      flush_s     = (state_r == ST_RUN) && flush;
      push_fire_s = strm.push_valid && push_ready_r;
      pop_fire_s  = (oq_occ_r != 2'd0) && strm.pop_ready;
      // Words already committed to the output queue after this cycle's pop.
      pending_s   = {1'b0, oq_occ_r} + {2'b00, inflight_r} - {2'b00, pop_fire_s};
      issue_s     = (state_r == ST_RUN) && (ram_cnt_r != 10'd0) && (pending_s < 3'd2);
      ret_s       = inflight_r && (state_r == ST_RUN);

      occ_after_pop_s = oq_occ_r - {1'b0, pop_fire_s};
      oq0_nxt_s       = pop_fire_s ? oq1_r : oq0_r;
      oq1_nxt_s       = oq1_r;
      oq_occ_nxt_s    = occ_after_pop_s;
      if (ret_s) begin
         oq_occ_nxt_s = occ_after_pop_s + 2'd1;
         case (occ_after_pop_s)
            2'd0:    oq0_nxt_s = ram_d_out;
            2'd1:    oq1_nxt_s = ram_d_out;
            default: oq1_nxt_s = oq1_r;
         endcase
      end else begin
         oq_occ_nxt_s = occ_after_pop_s;
      end

      if (flush_s) begin
         wptr_nxt_s    = '0;
         rptr_nxt_s    = '0;
         ram_cnt_nxt_s = 10'd0;
         count_nxt_s   = 10'd0;
         oq_occ_nxt_s  = 2'd0;
      end else begin
         wptr_nxt_s    = push_fire_s ? wptr_r + AW'(1'b1) : wptr_r;
         rptr_nxt_s    = issue_s ? rptr_r + AW'(1'b1) : rptr_r;
         ram_cnt_nxt_s = ram_cnt_r + {9'd0, push_fire_s} - {9'd0, issue_s};
         count_nxt_s   = count_r + {9'd0, push_fire_s} - {9'd0, pop_fire_s};
      end
   end

   // Controller state registers; reset clears pointers, queue and any read in flight.
   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         state_r        <= ST_RUN;
         wptr_r         <= '0;
         rptr_r         <= '0;
         ram_cnt_r      <= 10'd0;
         count_r        <= 10'd0;
         inflight_r     <= 1'b0;
         oq_occ_r       <= 2'd0;
         oq0_r          <= 32'd0;
         oq1_r          <= 32'd0;
         push_ready_r   <= 1'b0;
         almost_full_r  <= 1'b0;
         almost_empty_r <= 1'b1;
      end else begin
         state_r        <= state_nxt_s;
         wptr_r         <= wptr_nxt_s;
         rptr_r         <= rptr_nxt_s;
         ram_cnt_r      <= ram_cnt_nxt_s;
         count_r        <= count_nxt_s;
         inflight_r     <= issue_s;
         oq_occ_r       <= oq_occ_nxt_s;
         oq0_r          <= oq0_nxt_s;
         oq1_r          <= oq1_nxt_s;
         push_ready_r   <= (state_nxt_s == ST_RUN) && (count_nxt_s < 10'(DEPTH));
         almost_full_r  <= (count_nxt_s >= 10'(AF_LEVEL));
         almost_empty_r <= (count_nxt_s <= 10'(AE_LEVEL));
      end
   end

   assign strm.push_ready = push_ready_r;
   assign strm.pop_valid  = (oq_occ_r != 2'd0);
   assign strm.pop_data   = oq0_r;
   assign count           = count_r;
   assign almost_full     = almost_full_r;
   assign almost_empty    = almost_empty_r;
   assign ram_wen         = !push_fire_s;
   assign ram_ren         = !issue_s;
   assign ram_waddr       = wptr_r;
   assign ram_raddr       = rptr_r;
   assign ram_d_in        = strm.push_data;
   assign ram_wenb        = 32'hFFFF_FFFF;

endmodule

// File: doc/ram16k_fifo_ctrl.md
Name: ram16k_fifo_ctrl

Overview:
- Single-clock FIFO controller that sequences one DP_RAM16K instance (512 x 32, registered read, active-low wen/ren) as a first-word-fall-through queue.
- Owns all RAM control pins: pointers, write strobe, read strobe and write mask.
- Absorbs the RAM's one-cycle read latency with a 2-entry output queue, so pop throughput is one word per clock.
- Sits between a streaming producer and consumer in the fabric; both clock pins of the RAM are tied to clk.

Parameters:
- DEPTH, 512, RAM words available to the FIFO; power of two, at most 512.
- AW, 9, pointer width, log2(DEPTH).
- AF_LEVEL, 480, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 32, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  clock for the controller; also drives RAM rclk and wclk.
- R  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of all FIFO contents.
- push_valid  in  1  producer has a word.
- push_ready  out  1  controller accepts a word this cycle.
- push_data  in  32  write word.
- pop_valid  out  1  head word is available.
- pop_ready  in  1  consumer takes the head word.
- pop_data  out  32  head word.
- count  out  10  total words held: RAM + in-flight read + output queue.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- ram_wen  out  1  to RAM wen; active-low.
- ram_ren  out  1  to RAM ren; active-low.
- ram_waddr  out  AW  to RAM waddr.
- ram_raddr  out  AW  to RAM raddr.
- ram_d_in  out  32  to RAM d_in; equals push_data.
- ram_wenb  out  32  to RAM wenb; constant all-ones.
- ram_d_out  in  32  from RAM d_out.

Behaviour:
- Clock and reset: one clock, clk. Reset R is asynchronous and active-high.
- Values while R is high: wptr=rptr=0, ram_cnt=0, inflight=0, oq occupancy=0, state=RUN. Outputs: push_ready=0, pop_valid=0, pop_data=0, count=0, almost_full=0, almost_empty=1, ram_wen=1, ram_ren=1, both addresses 0.
- After R deasserts: push_ready=1 from the first clk edge onward.
- RAM contents are not cleared by R or flush; they are don't-care because the pointers are reset.
- Handshakes:
  - push fires on push_valid && push_ready. pop fires on pop_valid && pop_ready.
  - push_ready = (state==RUN) && (count < DEPTH). It is computed from registered count only; a pop in the same cycle does not free a slot that cycle.
- Write path:
  - On push fire, ram_wen=0, ram_waddr=wptr, and wptr increments at the edge, wrapping DEPTH-1 -> 0.
  - Otherwise ram_wen=1.
- Read issue:
  - Issue a read when state==RUN, ram_cnt>0, and (oq_occ + inflight - pop_fire) < 2.
  - On issue: ram_ren=0, ram_raddr=rptr; rptr increments with wrap; inflight<=1 at the edge.
  - Otherwise ram_ren=1 and inflight<=0.
  - ram_cnt counts written-but-not-issued words. A word written at edge E is first readable in the cycle after E, so there is no read-during-write hazard.
- Return:
  - When inflight==1, ram_d_out is valid this cycle and is written into the output queue at the next edge.
  - oq is a 2-entry FIFO. pop_data is its head; pop_valid = (oq_occ != 0).
- Latency: a push into an empty FIFO at edge E0 gives pop_valid=1 after edge E0+2.
- Steady state: with continuous push and pop, one word per cycle, no bubbles.
- count: incremented on push fire, decremented on pop fire; both together leave it unchanged. Range 0..DEPTH.
- almost_full and almost_empty are registered from the next value of count.
- Flush FSM, states RUN and FLUSH:
  - RUN -> FLUSH when flush=1. At that edge: pointers, ram_cnt, oq_occ and count go to 0; push and pop fires in that cycle are ignored.
  - FLUSH: push_ready=0, pop_valid=0, no read issued, any returning inflight word discarded.
  - FLUSH -> RUN unconditionally after one cycle. If flush is still high, the block re-enters FLUSH.
- Reset mid-operation: in-flight read discarded, no write strobe generated, the RAM output register is ignored.

Test Plan:
- Reset then a single push of 32'hDEAD_BEEF at edge E0 -> ram_wen=0 with ram_waddr=0 in that cycle; pop_valid=1 and pop_data=32'hDEAD_BEEF after edge E0+2; count=1, then 0 after the pop.
- Fill with no pops: 512 pushes of values 0..511 -> push_ready=0 once count=512; almost_full=1 from count=480. A 513th push_valid is not accepted and ram_wen stays 1.
- Streaming: continuous push and pop (pop_ready=1) of 2000 incrementing words -> output order preserved across pointer wrap (waddr 511 -> 0). One pop per cycle once pop_valid first asserts; count stays constant.
- Consumer backpressure: pop_ready toggling 0/1 randomly with 1000 words -> no loss or duplication, oq_occ never exceeds 2, data matches the scoreboard.
- Flush with inflight=1 and oq holding 2 words -> the following cycle has pop_valid=0, push_ready=0, count=0; the next push of 32'h1234 is the next popped word.
- Assert R while count=100 with a read in flight -> all outputs take their reset values immediately; after release count=0, almost_empty=1, and no stale word appears on pop.
